// File: rtl/cam_capture_rgb332_pkg.sv
// Shared definitions for the camera capture path: frame geometry, FSM
// encoding and the RGB565 -> RGB332 bit select also used by the display path.
package cam_capture_rgb332_pkg;

  localparam int CAM_AW        = 15;
  localparam int CAM_DW        = 8;
  localparam int CAM_H_PIX     = 160;
  localparam int CAM_V_PIX     = 120;
  localparam int CAM_FRAME_PIX = CAM_H_PIX * CAM_V_PIX;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } cap_state_e;

  // hi is the first byte on the bus (R5 G3-high), lo the second (G3-low B5).
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_pixel_pack.sv
// Byte-pair assembler: tracks byte phase, holds the first byte and
// registers one packed RGB332 write per completed pixel.
module cam_pixel_pack
  import cam_capture_rgb332_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  input  logic       store_i,
  output logic       pair_done_o,
  output logic       regwrite_o,
  output logic [7:0] data_o
);

  logic       phase_q, phase_d;
  logic [7:0] b1_q, b1_d;
  logic       regwrite_q, regwrite_d;
  logic [7:0] data_q, data_d;

  assign pair_done_o = byte_valid_i && phase_q;

  always_comb begin
    phase_d    = phase_q;
    b1_d       = b1_q;
    regwrite_d = 1'b0;
    data_d     = data_q;
    if (clear_i) begin
      phase_d = 1'b0;
    end else if (byte_valid_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        b1_d = byte_i;
      end else if (store_i) begin
        regwrite_d = 1'b1;
        data_d     = rgb565_to_rgb332(b1_q, byte_i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      b1_q       <= '0;
      regwrite_q <= 1'b0;
      data_q     <= '0;
    end else begin
      phase_q    <= phase_d;
      b1_q       <= b1_d;
      regwrite_q <= regwrite_d;
      data_q     <= data_d;
    end
  end

  assign regwrite_o = regwrite_q;
  assign data_o     = data_q;

endmodule

// File: rtl/cam_capture_rgb332.sv
// OV7670-style QQVGA capture: syncs the camera bus, frames it with vsync/href
// and writes packed RGB332 pixels to linear frame-buffer addresses.
module cam_capture_rgb332
  import cam_capture_rgb332_pkg::*;
#(
  parameter int AW    = CAM_AW,
  parameter int DW    = CAM_DW,
  parameter int H_PIX = CAM_H_PIX,
  parameter int V_PIX = CAM_V_PIX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_en,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy,
  output logic          overflow
);

  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_PIX + 1);

  logic       rv_q, rv2_q, rh_q, rh2_q;
  logic [7:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q  <= 1'b0;
      rv2_q <= 1'b0;
      rh_q  <= 1'b0;
      rh2_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      rv_q  <= cam_vsync;
      rv2_q <= rv_q;
      rh_q  <= cam_href;
      rh2_q <= rh_q;
      rd_q  <= cam_data;
    end
  end

  logic rv_fall, rv_rise, rh_fall;
  assign rv_fall = !rv_q && rv2_q;
  assign rv_rise = rv_q && !rv2_q;
  assign rh_fall = !rh_q && rh2_q;

  cap_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rv_fall && capture_en) state_d = ST_FRAME;
      ST_FRAME: if (rv_rise)               state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // vsync rise outranks everything else seen in the same cycle.
  logic frame_start, frame_end, line_end, byte_valid;

  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_end    = 1'b0;
    byte_valid  = 1'b0;
    case (state_q)
      ST_IDLE:  frame_start = rv_fall && capture_en;
      ST_FRAME: begin
        frame_end  = rv_rise;
        line_end   = !rv_rise && rh_fall;
        byte_valid = !rv_rise && rh_q;
      end
      default: ;
    endcase
  end

  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [YW-1:0] line_cnt_q, line_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ovf_q, ovf_d;
  logic          done_q;
  logic          pair_done, store_ok;
  logic [7:0]    pack_data;

  assign store_ok = (pix_x_q < XW'(H_PIX)) && (line_cnt_q < YW'(V_PIX));

  always_comb begin
    pix_x_d     = pix_x_q;
    line_base_d = line_base_q;
    line_cnt_d  = line_cnt_q;
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    if (frame_start) begin
      pix_x_d     = '0;
      line_base_d = '0;
      line_cnt_d  = '0;
      ovf_d       = 1'b0;
    end else if (line_end) begin
      // Only a line that stored something advances; pix_x>0 implies line_cnt<V_PIX.
      if (pix_x_q != '0) begin
        line_base_d = line_base_q + AW'(H_PIX);
        line_cnt_d  = line_cnt_q + YW'(1);
        pix_x_d     = '0;
      end
    end else if (pair_done) begin
      if (store_ok) begin
        addr_d  = line_base_q + AW'(pix_x_q);
        pix_x_d = pix_x_q + XW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x_q     <= '0;
      line_base_q <= '0;
      line_cnt_q  <= '0;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pix_x_q     <= pix_x_d;
      line_base_q <= line_base_d;
      line_cnt_q  <= line_cnt_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
      done_q      <= frame_end;
    end
  end

  cam_pixel_pack u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (frame_start || frame_end || line_end),
    .byte_valid_i(byte_valid),
    .byte_i      (rd_q),
    .store_i     (store_ok),
    .pair_done_o (pair_done),
    .regwrite_o  (regwrite),
    .data_o      (pack_data)
  );

  assign addr_in    = addr_q;
  assign data_in    = DW'(pack_data);
  assign frame_done = done_q;
  assign busy       = (state_q == ST_FRAME);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Bench for cam_capture_rgb332: camera-bus driver, behavioural frame model
// with an expected-write queue, per-cycle write compare and end summary.
module tb_cam_capture_rgb332;

  localparam int H      = 160;
  localparam int V      = 120;
  localparam int HBLANK = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [14:0] addr_in;
  logic [7:0]  data_in;
  logic        regwrite;
  logic        frame_done;
  logic        busy;
  logic        overflow;

  always #5 clk = ~clk;

  cam_capture_rgb332 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_en(capture_en),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .regwrite  (regwrite),
    .frame_done(frame_done),
    .busy      (busy),
    .overflow  (overflow)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [22:0] exp_q[$];            // {addr[14:0], data[7:0]}
  int          wr_cnt    = 0;
  int          done_seen = 0;
  int          exp_done  = 0;
  logic [14:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  bit          chk_en    = 1'b0;
  bit          prev_wr   = 1'b0;
  bit          prev_done = 1'b0;

  // behavioural frame model
  bit m_cap  = 1'b0;
  bit m_ovf  = 1'b0;
  int m_line = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] model_pix(input int b1, input int b2);
    return 8'((b1 / 32) * 32 + (b1 % 8) * 4 + (b2 / 8) % 4);
  endfunction

  // One completed byte pair k of the current line.
  task automatic model_pair(input int k, input int b1, input int b2);
    if (m_cap) begin
      if (m_line < V && k < H)
        exp_q.push_back({15'(m_line * H + k), model_pix(b1, b2)});
      else
        m_ovf = 1'b1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
    end else if (chk_en) begin
      if (regwrite) begin
        wr_cnt++;
        last_addr = addr_in;
        last_data = data_in;
        check("write_gap", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data 0x%02h, expected no write", addr_in, data_in);
        end else begin
          logic [22:0] e;
          e = exp_q.pop_front();
          check("write_addr", 32'(addr_in), 32'(e[22:8]));
          check("write_data", 32'(data_in), 32'(e[7:0]));
        end
      end
      if (frame_done) begin
        done_seen++;
        check("frame_done_width", 32'(prev_done), 32'd0);
      end
      prev_wr   = regwrite;
      prev_done = frame_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frame_begin();
    @(negedge clk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    m_cap  = capture_en;
    m_line = 0;
    if (m_cap) m_ovf = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_at_start", 32'(busy), 32'(m_cap));
    check("overflow_at_start", 32'(overflow), 32'(m_ovf));
  endtask

  // n bytes on one href line; abort raises vsync while href is still high.
  task automatic drive_line(input int n, input bit abort, input bit fixed,
                            input int f1, input int f2);
    int b;
    int b1;
    b1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      b = fixed ? ((i % 2 == 0) ? f1 : f2) : int'($urandom_range(0, 255));
      cam_data = 8'(b);
      if (i % 2 == 0) b1 = b;
      else            model_pair(i / 2, b1, b);
    end
    if (m_cap && n >= 2 && m_line < V) m_line++;
    if (abort) begin
      @(negedge clk);
      cam_vsync = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cam_data = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      cam_href = 1'b0;
    end else begin
      @(negedge clk);
      cam_href = 1'b0;
      repeat (HBLANK - 1) @(negedge clk);
      check("busy_in_line", 32'(busy), 32'(m_cap));
      check("overflow_in_line", 32'(overflow), 32'(m_ovf));
    end
  endtask

  task automatic frame_end();
    @(negedge clk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    if (m_cap) exp_done++;
    m_cap = 1'b0;
    repeat (6) @(negedge clk);
    check("frame_done_count", 32'(done_seen), 32'(exp_done));
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("overflow_after_frame", 32'(overflow), 32'(m_ovf));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    rst_n      = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr_in), 32'd0);
    check("rst_data", 32'(data_in), 32'd0);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // reset asserted in the middle of a captured line
    capture_en = 1'b1;
    frame_begin();
    chk_en = 1'b0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_regwrite", 32'(regwrite), 32'd0);
    check("midrst_addr", 32'(addr_in), 32'd0);
    check("midrst_data", 32'(data_in), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    m_cap = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    w0 = wr_cnt;
    drive_line(40, 1'b0, 1'b0, 0, 0);
    check("no_write_after_reset", 32'(wr_cnt - w0), 32'd0);
    frame_end();

    // full frame of pure red
    w0 = wr_cnt;
    frame_begin();
    for (int l = 0; l < V; l++) drive_line(2 * H, 1'b0, 1'b1, 'hF8, 'h00);
    frame_end();
    check("full_frame_writes", 32'(wr_cnt - w0), 32'd19200);
    check("full_frame_last_addr", 32'(last_addr), 32'd19199);
    check("full_frame_last_data", 32'(last_data), 32'hE0);
    check("full_frame_overflow", 32'(overflow), 32'd0);

    // packing pins, random lines, long line
    frame_begin();
    drive_line(2, 1'b0, 1'b1, 'h07, 'hE0);
    check("pack_07e0", 32'(last_data), 32'h1C);
    check("pack_07e0_addr", 32'(last_addr), 32'd0);
    drive_line(2, 1'b0, 1'b1, 'h00, 'h1F);
    check("pack_001f", 32'(last_data), 32'h03);
    check("pack_001f_addr", 32'(last_addr), 32'd160);
    drive_line(2, 1'b0, 1'b1, 'hA5, 'h5A);
    check("pack_a55a", 32'(last_data), 32'hB7);
    check("pack_a55a_addr", 32'(last_addr), 32'd320);
    repeat (4) drive_line(int'($urandom_range(2, 320)), 1'b0, 1'b0, 0, 0);
    drive_line(330, 1'b0, 1'b0, 0, 0);
    check("long_line_overflow", 32'(overflow), 32'd1);
    drive_line(20, 1'b0, 1'b0, 0, 0);
    frame_end();

    // overflow clears; odd byte count; vsync rise mid-line
    frame_begin();
    check("overflow_cleared", 32'(overflow), 32'd0);
    drive_line(321, 1'b0, 1'b0, 0, 0);
    check("odd_line_overflow", 32'(overflow), 32'd0);
    drive_line(51, 1'b1, 1'b0, 0, 0);
    frame_end();

    // capture disabled at the vsync fall, raised mid-frame
    capture_en = 1'b0;
    w0 = wr_cnt;
    frame_begin();
    drive_line(40, 1'b0, 1'b0, 0, 0);
    capture_en = 1'b1;
    drive_line(40, 1'b0, 1'b0, 0, 0);
    check("disabled_busy", 32'(busy), 32'd0);
    frame_end();
    check("disabled_writes", 32'(wr_cnt - w0), 32'd0);

    // capture_en dropped mid-frame: frame completes
    frame_begin();
    drive_line(64, 1'b0, 1'b0, 0, 0);
    capture_en = 1'b0;
    drive_line(64, 1'b0, 1'b0, 0, 0);
    frame_end();
    capture_en = 1'b1;

    // more lines than the frame holds
    frame_begin();
    for (int l = 0; l < V + 1; l++) drive_line(2, 1'b0, 1'b0, 0, 0);
    frame_end();
    check("extra_line_last_addr", 32'(last_addr), 32'd19040);
    check("extra_line_overflow", 32'(overflow), 32'd1);

    // random frames
    for (int f = 0; f < 4; f++) begin
      int nl;
      capture_en = ($urandom_range(0, 3) != 0);
      frame_begin();
      nl = int'($urandom_range(1, 6));
      for (int l = 0; l < nl; l++)
        drive_line(int'($urandom_range(1, 340)), (l == nl - 1) && ($urandom_range(0, 1) == 1), 1'b0, 0, 0);
      frame_end();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
